uart_remote_panel: RTL and testbench
====================================

Name: uart_remote_panel

Overview:
- Host/panel-side counterpart of the tic-tac-toe board's UART controller.
- Outbound: encodes debounced panel button pulses into ASCII key bytes, queues them and transmits them to the game board.
- Inbound: receives the board's status stream ('0'..'8' cursor, 'W' win, 'C' heartbeat) and presents cursor, win and link-alive state to panel LEDs/7-seg.
- Sits between panel button conditioning and the serial pins; reuses the existing uart_tx/uart_rx serializers.

Parameters:
- FIFO_DEPTH, 4, key-byte queue entries; power of two, >= 2.
- LINK_TIMEOUT, 32'd100_000_000, clk cycles with no valid status byte before link_up drops (2 s at 50 MHz, twice the board heartbeat).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_in  in  1  serial line from game board
- tx_out  out  1  serial line to game board
- btn_up, btn_down, btn_left, btn_right, btn_enter, btn_space  in  1 each  single-cycle debounced press pulses
- cursor_cell  out  4  last reported cursor cell, 0..8
- cursor_valid  out  1  cursor_cell holds a received value
- win  out  1  board reported a win
- link_up  out  1  status byte received within LINK_TIMEOUT
- status_strobe  out  1  1-cycle pulse per accepted status byte
- bad_byte  out  1  1-cycle pulse per unrecognised received byte
- key_dropped  out  1  1-cycle pulse when a press is lost (FIFO full and key already pending)

Behaviour:
- Reset (sync): all outputs 0, cursor_cell=0, FIFO empty, pending mask 0, timers 0, TX FSM in IDLE. Reset mid-frame abandons the byte; nothing is resent.
- Key codes (decided): up 8'h77 'w', down 8'h73 's', left 8'h61 'a', right 8'h64 'd', enter 8'h0D, space 8'h20.
- Pending mask (6 bits): each cycle OR in the btn_* pulses.
  - If the FIFO is not full, push the code of the highest-priority pending bit (up>down>left>right>enter>space) and clear that bit. One push per cycle.
  - A pulse on a bit that is already pending while the FIFO is full: press dropped, key_dropped pulses. A repeat press while not full merges silently.
  - A pulse arriving in the same cycle its bit is pushed re-sets the bit (the new press is kept).
- FIFO: synchronous, registered. Simultaneous push and pop is allowed when full or empty only if the pop is legal; count stays consistent. Pointers wrap modulo FIFO_DEPTH.
- TX FSM:
  - IDLE: if FIFO not empty and !tx_busy, pop, drive tx_data and pulse send for 1 cycle, go to WAIT_BUSY.
  - WAIT_BUSY: on tx_busy=1 go to WAIT_DONE. After 4 cycles without busy, return to IDLE (byte considered sent).
  - WAIT_DONE: on tx_busy=0 go to IDLE.
  - Latency: btn pulse in cycle N yields send in cycle N+2 when idle and empty (pending register -> FIFO -> send).
- RX parser, on uart_rx data_valid:
  - 8'h30..8'h38: cursor_cell <= byte-8'h30 (low 4 bits), cursor_valid <= 1, win <= 0.
  - 8'h57 'W': win <= 1; cursor unchanged.
  - 8'h43 'C': heartbeat, no state change.
  - All three accepted bytes: status_strobe pulse, link timer <= 0, link_up <= 1 in the same cycle.
  - Any other byte (including '9'): bad_byte pulse; no other state change; the timer is not reset.
- Link timer: increments when no accepted byte, saturating at LINK_TIMEOUT. On reaching LINK_TIMEOUT: link_up <= 0, cursor_valid <= 0, win <= 0; cursor_cell retained.
  - An accepted byte in the timeout cycle takes precedence (link stays up).

Decomposition:
- Shared package uart_keys_pkg: key ASCII constants, status constants (8'h57, 8'h43, 8'h30), priority order.
- One sub-module: key_fifo (parameterised DEPTH/width 8; push, pop, full, empty, dout).
- Instances of the existing uart_tx and uart_rx; parser and TX FSM stay in the top.

Test Plan:
- btn_right pulse, idle line -> send 1 cycle later at N+2 with tx_data=8'h64; tx_out frame carries 0x64.
- btn_up, btn_enter and btn_space pulsed in the same cycle -> bytes 0x77, 0x0D, 0x20 transmitted in that order; no key_dropped.
- tx_busy held high, 4 btn_left pulses then 2 more btn_left pulses -> FIFO full with 4×0x61, pending bit set, one key_dropped pulse on the 6th press.
- RX bytes '5', 'W', 'C' -> cursor_cell=5, cursor_valid=1, win=1; three status_strobe pulses; link_up=1.
- RX byte 8'h39 -> bad_byte pulse; cursor_cell unchanged.
- With LINK_TIMEOUT=100 and no RX after '3' -> link_up, cursor_valid and win drop exactly 100 cycles later; cursor_cell stays 3; reset asserted mid-transmission -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_keys_pkg.sv
// Shared key/status byte codes and TX state encoding for the
// remote panel. Key index order doubles as press priority.
package uart_keys_pkg;

    localparam int NKEYS = 6;

    localparam logic [7:0] KEY_UP    = 8'h77;
    localparam logic [7:0] KEY_DOWN  = 8'h73;
    localparam logic [7:0] KEY_LEFT  = 8'h61;
    localparam logic [7:0] KEY_RIGHT = 8'h64;
    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_SPACE = 8'h20;

    localparam logic [7:0] ST_WIN    = 8'h57;
    localparam logic [7:0] ST_BEAT   = 8'h43;
    localparam logic [7:0] ST_DIGIT0 = 8'h30;

    // Lower index wins when several keys are pending.
    typedef enum logic [2:0] {
        K_UP, K_DOWN, K_LEFT, K_RIGHT, K_ENTER, K_SPACE
    } key_e;

    typedef enum logic [1:0] {
        TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE
    } tx_state_e;

    function automatic logic [7:0] key_code(input logic [2:0] k);
        logic [7:0] c;
        c = KEY_SPACE;
        unique case (k)
            K_UP:    c = KEY_UP;
            K_DOWN:  c = KEY_DOWN;
            K_LEFT:  c = KEY_LEFT;
            K_RIGHT: c = KEY_RIGHT;
            K_ENTER: c = KEY_ENTER;
            default: c = KEY_SPACE;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] first_key(input logic [NKEYS-1:0] m);
        logic [2:0] k;
        k = 3'd0;
        for (int i = NKEYS - 1; i >= 0; i--)
            if (m[i]) k = 3'(i);
        return k;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for queued key bytes.
// A pop on an empty queue is ignored; push when full only with a pop.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 deserializer sampling mid-bit; pulses valid_o on a good stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o
);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  sync_q;
    logic        act_q, valid_q;
    logic [15:0] cnt_q;
    logic [3:0]  bit_q;
    logic [7:0]  sh_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= 2'b11;
            act_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            valid_q <= 1'b0;
            if (!act_q) begin
                if (!sync_q[1]) begin
                    act_q <= 1'b1;
                    cnt_q <= HALF;
                    bit_q <= '0;
                end
            end else if (cnt_q != LAST) begin
                cnt_q <= cnt_q + 16'd1;
            end else begin
                cnt_q <= '0;
                if (bit_q == 4'd0) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    act_q <= !sync_q[1];
                    bit_q <= 4'd1;
                end else if (bit_q == 4'd9) begin
                    act_q   <= 1'b0;
                    valid_q <= sync_q[1];
                end else begin
                    sh_q  <= {sync_q[1], sh_q[7:1]};
                    bit_q <= bit_q + 4'd1;
                end
            end
        end
    end

    assign data_o  = sh_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serializer: latches data on send, busy until the stop bit ends.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       send_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o
);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [9:0]  sh_q;
    logic [15:0] cnt_q;
    logic [3:0]  bit_q;
    logic        busy_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sh_q   <= '1;
            cnt_q  <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
        end else if (!busy_q) begin
            if (send_i) begin
                sh_q   <= {1'b1, data_i, 1'b0};
                cnt_q  <= '0;
                bit_q  <= '0;
                busy_q <= 1'b1;
            end
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 16'd1;
        end else begin
            cnt_q <= '0;
            sh_q  <= {1'b1, sh_q[9:1]};
            if (bit_q == 4'd9) busy_q <= 1'b0;
            else               bit_q  <= bit_q + 4'd1;
        end
    end

    assign tx_o   = busy_q ? sh_q[0] : 1'b1;
    assign busy_o = busy_q;

endmodule

// File: rtl/uart_remote_panel.sv
// Panel side of the tic-tac-toe link: buttons out as key bytes,
// board status stream in as cursor/win/link indicators.
module uart_remote_panel
    import uart_keys_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] LINK_TIMEOUT = 32'd100_000_000,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic       tx_out,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_enter,
    input  logic       btn_space,
    output logic [3:0] cursor_cell,
    output logic       cursor_valid,
    output logic       win,
    output logic       link_up,
    output logic       status_strobe,
    output logic       bad_byte,
    output logic       key_dropped
);
    logic [NKEYS-1:0] btn, pend_q, pend_d, pick;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       push_code, tx_data, rx_data;
    logic             tx_send, tx_busy, rx_valid;
    tx_state_e        state_q, state_d;
    logic [1:0]       wait_q, wait_d;
    logic             drop_q, drop_d;
    logic [3:0]       cell_q, cell_d;
    logic             cval_q, cval_d, win_q, win_d, up_q, up_d;
    logic             strobe_q, strobe_d, bad_q, bad_d, accept;
    logic [31:0]      timer_q, timer_d;

    assign btn = {btn_space, btn_enter, btn_right,
                  btn_left, btn_down, btn_up};

    always_comb begin
        fifo_push = 1'b0;
        pick      = '0;
        push_code = key_code(first_key(pend_q));
        if (!fifo_full && |pend_q) begin
            fifo_push = 1'b1;
            pick      = NKEYS'(1) << first_key(pend_q);
        end
        pend_d = (pend_q & ~pick) | btn;
        drop_d = fifo_full && |(btn & pend_q);
    end

    key_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (fifo_push),
        .din_i   (push_code),
        .pop_i   (fifo_pop),
        .dout_o  (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        fifo_pop = 1'b0;
        tx_send  = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    fifo_pop = 1'b1;
                    tx_send  = 1'b1;
                    wait_d   = '0;
                    state_d  = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (tx_busy)              state_d = TX_WAIT_DONE;
                else if (wait_q == 2'd3)  state_d = TX_IDLE;
                else                      wait_d  = wait_q + 2'd1;
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk_i   (clk),
        .reset_i (reset),
        .send_i  (tx_send),
        .data_i  (tx_data),
        .tx_o    (tx_out),
        .busy_o  (tx_busy)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i   (clk),
        .reset_i (reset),
        .rx_i    (rx_in),
        .data_o  (rx_data),
        .valid_o (rx_valid)
    );

    always_comb begin
        cell_d   = cell_q;
        cval_d   = cval_q;
        win_d    = win_q;
        up_d     = up_q;
        timer_d  = timer_q;
        strobe_d = 1'b0;
        bad_d    = 1'b0;
        accept   = 1'b0;
        if (rx_valid) begin
            unique case (1'b1)
                (rx_data >= ST_DIGIT0 &&
                 rx_data <= ST_DIGIT0 + 8'd8): begin
                    cell_d = 4'(rx_data - ST_DIGIT0);
                    cval_d = 1'b1;
                    win_d  = 1'b0;
                    accept = 1'b1;
                end
                (rx_data == ST_WIN): begin
                    win_d  = 1'b1;
                    accept = 1'b1;
                end
                (rx_data == ST_BEAT): accept = 1'b1;
                default: bad_d = 1'b1;
            endcase
        end
        // An accepted byte overrides a timeout landing in the same cycle.
        if (accept) begin
            strobe_d = 1'b1;
            up_d     = 1'b1;
            timer_d  = '0;
        end else if (timer_q != LINK_TIMEOUT) begin
            timer_d = timer_q + 32'd1;
            if (timer_d == LINK_TIMEOUT) begin
                up_d   = 1'b0;
                cval_d = 1'b0;
                win_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q   <= '0;
            state_q  <= TX_IDLE;
            wait_q   <= '0;
            drop_q   <= 1'b0;
            cell_q   <= '0;
            cval_q   <= 1'b0;
            win_q    <= 1'b0;
            up_q     <= 1'b0;
            strobe_q <= 1'b0;
            bad_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            state_q  <= state_d;
            wait_q   <= wait_d;
            drop_q   <= drop_d;
            cell_q   <= cell_d;
            cval_q   <= cval_d;
            win_q    <= win_d;
            up_q     <= up_d;
            strobe_q <= strobe_d;
            bad_q    <= bad_d;
            timer_q  <= timer_d;
        end
    end

    assign cursor_cell   = cell_q;
    assign cursor_valid  = cval_q;
    assign win           = win_q;
    assign link_up       = up_q;
    assign status_strobe = strobe_q;
    assign bad_byte      = bad_q;
    assign key_dropped   = drop_q;

endmodule

// File: tb/tb_uart_remote_panel.sv
// Directed and randomized checks of the remote panel against a
// byte-level reference model of keys, status stream and link timeout.
module tb_uart_remote_panel;

    localparam int C  = 4;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       tx_out;
    logic       btn_up = 0, btn_down = 0, btn_left = 0;
    logic       btn_right = 0, btn_enter = 0, btn_space = 0;
    logic [3:0] cursor_cell;
    logic       cursor_valid, win, link_up;
    logic       status_strobe, bad_byte, key_dropped;

    uart_remote_panel #(
        .FIFO_DEPTH   (4),
        .LINK_TIMEOUT (32'(TO)),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_in         (rx_in),
        .tx_out        (tx_out),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_enter     (btn_enter),
        .btn_space     (btn_space),
        .cursor_cell   (cursor_cell),
        .cursor_valid  (cursor_valid),
        .win           (win),
        .link_up       (link_up),
        .status_strobe (status_strobe),
        .bad_byte      (bad_byte),
        .key_dropped   (key_dropped)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int n_strobe = 0, n_bad = 0, n_drop = 0;
    int last_strobe = 0;
    bit mon_en = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] codes [6] = '{8'h77, 8'h73, 8'h61, 8'h64, 8'h0D, 8'h20};

    // reference model of the status outputs
    int m_cell = 0, m_valid = 0, m_win = 0, m_up = 0;
    int m_strobe = 0, m_bad = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (status_strobe === 1'b1) begin
            n_strobe++;
            last_strobe = cyc;
        end
        if (bad_byte === 1'b1) n_bad++;
        if (key_dropped === 1'b1) n_drop++;
    end

    always begin
        logic [7:0] b;
        @(negedge tx_out);
        if (mon_en) begin
            repeat (C / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(posedge clk);
                b[i] = tx_out;
            end
            repeat (C) @(posedge clk);
            got.push_back(b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [5:0] m);
        btn_up    = m[0];
        btn_down  = m[1];
        btn_left  = m[2];
        btn_right = m[3];
        btn_enter = m[4];
        btn_space = m[5];
    endtask

    task automatic expect_keys(input logic [5:0] m);
        for (int i = 0; i < 6; i++)
            if (m[i]) exp_q.push_back(codes[i]);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (got.size() < exp_q.size() && t < 3000) begin
            step(1);
            t++;
        end
        step(80);
        chk({tag, "_count"}, got.size(), exp_q.size());
        while (got.size() > 0 && exp_q.size() > 0)
            chk(tag, got.pop_front(), exp_q.pop_front());
        got.delete();
        exp_q.delete();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_in = 1'b0;
        step(C);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            step(C);
        end
        rx_in = 1'b1;
        step(C + 4);
        if (b >= 8'h30 && b <= 8'h38) begin
            m_cell = int'(b) - 48;
            m_valid = 1;
            m_win = 0;
            m_strobe++;
            m_up = 1;
        end else if (b == 8'h57) begin
            m_win = 1;
            m_strobe++;
            m_up = 1;
        end else if (b == 8'h43) begin
            m_strobe++;
            m_up = 1;
        end else begin
            m_bad++;
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_cell"}, cursor_cell, m_cell);
        chk({tag, "_valid"}, cursor_valid, m_valid);
        chk({tag, "_win"}, win, m_win);
        chk({tag, "_link"}, link_up, m_up);
        chk({tag, "_strobes"}, n_strobe, m_strobe);
        chk({tag, "_bads"}, n_bad, m_bad);
    endtask

    initial begin
        logic [5:0] m;
        logic [7:0] b;
        logic [7:0] acc [11];
        int lows;

        for (int k = 0; k < 9; k++) acc[k] = 8'(8'h30 + k);
        acc[9]  = 8'h57;
        acc[10] = 8'h43;

        step(4);
        reset = 1'b0;
        step(1);
        chk("rst_cell", cursor_cell, 0);
        chk("rst_valid", cursor_valid, 0);
        chk("rst_win", win, 0);
        chk("rst_link", link_up, 0);
        chk("rst_strobe", status_strobe, 0);
        chk("rst_drop", key_dropped, 0);
        chk("rst_tx", tx_out, 1);
        mon_en = 1;

        // right key: send two cycles after the press, then overflow
        set_btn(6'b001000);
        step(1);
        set_btn(6'b000000);
        chk("right_n1_send", dut.tx_send, 0);
        step(1);
        chk("right_n2_send", dut.tx_send, 1);
        chk("right_n2_data", dut.tx_data, 8'h64);
        exp_q.push_back(8'h64);
        btn_left = 1'b1;
        step(6);
        btn_left = 1'b0;
        chk("fifo_full", dut.fifo_full, 1);
        step(2);
        chk("drop_count", n_drop, 1);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h61);
        drain("overflow_bytes");

        // three keys in one cycle come out in priority order
        set_btn(6'b110001);
        step(1);
        set_btn(6'b000000);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h20);
        drain("multi_bytes");
        chk("multi_nodrop", n_drop, 1);

        for (int r = 0; r < 6; r++) begin
            m = 6'($urandom_range(1, 63));
            set_btn(m);
            step(1);
            set_btn(6'b000000);
            expect_keys(m);
            drain("rand_keys");
        end
        chk("rand_nodrop", n_drop, 1);

        rx_byte(8'h35);
        chk_status("rx5");
        rx_byte(8'h57);
        chk_status("rxW");
        rx_byte(8'h43);
        chk_status("rxC");
        rx_byte(8'h39);
        chk_status("rx9");

        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) b = acc[$urandom_range(0, 10)];
            else            b = 8'($urandom_range(0, 255));
            rx_byte(b);
            chk_status("rx_rand");
        end

        rx_byte(8'h57);
        rx_byte(8'h33);
        chk_status("rx3");
        while (cyc < last_strobe + TO - 1) @(negedge clk);
        chk("to_before_link", link_up, 1);
        chk("to_before_win", win, 0);
        @(negedge clk);
        chk("to_link", link_up, 0);
        chk("to_valid", cursor_valid, 0);
        chk("to_win", win, 0);
        chk("to_cell", cursor_cell, 3);

        // reset in the middle of an outgoing frame
        mon_en = 0;
        step(1);
        set_btn(6'b000010);
        step(1);
        set_btn(6'b000000);
        step(15);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_rst_cell", cursor_cell, 0);
        chk("mid_rst_tx", tx_out, 1);
        chk("mid_rst_valid", cursor_valid, 0);
        chk("mid_rst_link", link_up, 0);
        chk("mid_rst_drop", key_dropped, 0);
        chk("mid_rst_bad", bad_byte, 0);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_out !== 1'b1) lows++;
            step(1);
        end
        chk("no_resend", lows, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
